// File: rtl/imem_responder_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder
package imem_pkg;
  typedef enum logic {S_LOAD, S_RUN} state_t;
  localparam int WORD_W = 32;
  localparam int BYTE_OFS_W = 2;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: loader, fetch request and fetch response channels
interface imem_responder_if #(parameter int MEM_WORDS = 1024);
  localparam int AW = $clog2(MEM_WORDS);
  logic load_valid;
  logic load_ready;
  logic [31:0] load_data;
  logic load_last;
  logic [AW:0] load_count;
  logic run;
  logic req_valid;
  logic req_ready;
  logic [31:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_data;
  logic rsp_err;
  modport master (
    output load_valid, load_data, load_last, req_valid, req_addr, rsp_ready,
    input load_ready, load_count, run, req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input load_valid, load_data, load_last, req_valid, req_addr, rsp_ready,
    output load_ready, load_count, run, req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_responder_store.sv
// imem_store: 1R1W word array with a registered read port
module imem_store import imem_pkg::*; #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              re,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [MEM_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: loads a program stream, then serves fetches with one-cycle latency
module imem_responder import imem_pkg::*; #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input logic clk,
  input logic reset,
  imem_responder_if.slave bus
);
  state_t state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic err_q, err_d;
  logic run, load_hs, req_rdy, req_hs, bad;
  logic [WORD_W-1:0] rd_data;
  always_comb begin
    run = state_q == S_RUN;
    load_hs = bus.load_valid && !run;
    req_rdy = run && (!rsp_valid_q || bus.rsp_ready);
    req_hs = bus.req_valid && req_rdy;
    bad = |bus.req_addr[BYTE_OFS_W-1:0] || |bus.req_addr[WORD_W-1:AW+BYTE_OFS_W];
    cnt_d = cnt_q + {{AW{1'b0}}, load_hs};
    state_d = load_hs && (bus.load_last || &cnt_q[AW-1:0]) ? S_RUN : state_q;
    rsp_valid_d = req_hs || (rsp_valid_q && !bus.rsp_ready);
    err_d = req_hs ? bad : err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      err_q <= err_d;
    end
  end
  imem_store #(.MEM_WORDS(MEM_WORDS)) u_store (
    .clk(clk),
    .we(load_hs),
    .wr_addr(cnt_q[AW-1:0]),
    .wr_data(bus.load_data),
    .re(req_hs && !bad),
    .rd_addr(bus.req_addr[AW+BYTE_OFS_W-1:BYTE_OFS_W]),
    .rd_data(rd_data)
  );
  // rd_data is unreset RAM output, so the valid/err gating also yields the reset value
  assign bus.rsp_data = rsp_valid_q && !err_q ? rd_data : NOP;
  assign bus.rsp_err = err_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.req_ready = req_rdy;
  assign bus.load_ready = !run;
  assign bus.run = run;
  assign bus.load_count = cnt_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks on a 1024-word and a 4-word responder
module tb_imem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst4 = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] prog [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
  logic [31:0] held;
  imem_responder_if #(.MEM_WORDS(1024)) b ();
  imem_responder_if #(.MEM_WORDS(4)) b4 ();
  imem_responder #(.MEM_WORDS(1024)) dut (.clk(clk), .reset(reset), .bus(b));
  imem_responder #(.MEM_WORDS(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    b.load_valid = 0; b.load_data = 0; b.load_last = 0;
    b.req_valid = 0; b.req_addr = 0; b.rsp_ready = 1;
    b4.load_valid = 0; b4.load_data = 0; b4.load_last = 0;
    b4.req_valid = 0; b4.req_addr = 0; b4.rsp_ready = 1;
  endtask
  task automatic test_reset();
    idle();
    step(); step();
    total++; if (b.load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%b exp=1", b.load_ready); end
    total++; if (b.run !== 1'b0) begin bad++; $display("FAIL rst_run got=%b exp=0", b.run); end
    total++; if (b.load_count !== 11'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", b.load_count); end
    total++; if (b.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", b.req_ready); end
    total++; if ({b.rsp_valid, b.rsp_err, b.rsp_data} !== 34'd0) begin bad++; $display("FAIL rst_rsp got v=%b e=%b d=%h exp 0/0/0", b.rsp_valid, b.rsp_err, b.rsp_data); end
    reset = 0;
  endtask
  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      b.load_valid = 1; b.load_data = prog[i]; b.load_last = (i == 3);
      step();
    end
    b.load_valid = 0; b.load_last = 0;
    total++; if (b.load_count !== 11'd4) begin bad++; $display("FAIL load_count got=%0d exp=4", b.load_count); end
    total++; if (b.run !== 1'b1 || b.load_ready !== 1'b0) begin bad++; $display("FAIL load_run got run=%b lr=%b exp 1/0", b.run, b.load_ready); end
    b.load_valid = 1; b.load_data = 32'hFFFF_FFFF;
    step();
    b.load_valid = 0;
    total++; if (b.load_count !== 11'd4) begin bad++; $display("FAIL load_ignored got=%0d exp=4", b.load_count); end
  endtask
  task automatic test_fetch();
    b.req_valid = 1; b.req_addr = 32'h8; b.rsp_ready = 1;
    total++; if (b.req_ready !== 1'b1) begin bad++; $display("FAIL fetch_req_ready got=%b exp=1", b.req_ready); end
    step();
    b.req_valid = 0;
    total++; if (b.rsp_valid !== 1'b1 || b.rsp_data !== 32'h01095020 || b.rsp_err !== 1'b0) begin bad++; $display("FAIL fetch8 got v=%b d=%h e=%b exp 1/01095020/0", b.rsp_valid, b.rsp_data, b.rsp_err); end
    step();
    total++; if (b.rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_clear got=%b exp=0", b.rsp_valid); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'hC};
    logic [31:0] exp [3] = '{32'h20080005, 32'h20090003, 32'hAC0A0000};
    for (int i = 0; i < 3; i++) begin
      b.req_valid = 1; b.req_addr = addrs[i];
      step();
      total++; if (b.rsp_valid !== 1'b1 || b.rsp_data !== exp[i]) begin bad++; $display("FAIL b2b[%0d] got v=%b d=%h exp 1/%h", i, b.rsp_valid, b.rsp_data, exp[i]); end
      total++; if (b.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, b.req_ready); end
    end
    b.req_valid = 0;
    step();
    total++; if (b.rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", b.rsp_valid); end
  endtask
  task automatic test_backpressure();
    b.rsp_ready = 0; b.req_valid = 1; b.req_addr = 32'h4;
    step();
    held = b.rsp_data;
    total++; if (held !== 32'h20090003) begin bad++; $display("FAIL bp_first got=%h exp=20090003", held); end
    for (int i = 0; i < 3; i++) begin
      total++; if (b.req_ready !== 1'b0 || b.rsp_valid !== 1'b1 || b.rsp_data !== 32'h20090003) begin bad++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h exp 0/1/20090003", i, b.req_ready, b.rsp_valid, b.rsp_data); end
      step();
    end
    b.rsp_ready = 1;
    #1;
    total++; if (b.req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", b.req_ready); end
    step();
    b.req_valid = 0;
    total++; if (b.rsp_valid !== 1'b1 || b.rsp_data !== 32'h20090003) begin bad++; $display("FAIL bp_second got v=%b d=%h exp 1/20090003", b.rsp_valid, b.rsp_data); end
    step();
    total++; if (b.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", b.rsp_valid); end
  endtask
  task automatic test_errors();
    b.req_valid = 1; b.req_addr = 32'h6;
    step();
    total++; if (b.rsp_err !== 1'b1 || b.rsp_data !== 32'h0) begin bad++; $display("FAIL err_misaligned got e=%b d=%h exp 1/0", b.rsp_err, b.rsp_data); end
    b.req_addr = 32'h0000_1000;
    step();
    total++; if (b.rsp_err !== 1'b1 || b.rsp_data !== 32'h0) begin bad++; $display("FAIL err_range got e=%b d=%h exp 1/0", b.rsp_err, b.rsp_data); end
    b.req_addr = 32'h0000_0FFC;
    step();
    total++; if (b.rsp_err !== 1'b0 || b.rsp_valid !== 1'b1) begin bad++; $display("FAIL err_top_word got e=%b v=%b exp 0/1", b.rsp_err, b.rsp_valid); end
    b.req_addr = 32'h0;
    step();
    b.req_valid = 0;
    total++; if (b.rsp_err !== 1'b0 || b.rsp_data !== 32'h20080005) begin bad++; $display("FAIL err_recover got e=%b d=%h exp 0/20080005", b.rsp_err, b.rsp_data); end
    step();
  endtask
  task automatic test_full_depth();
    rst4 = 0;
    for (int i = 0; i < 4; i++) begin
      b4.load_valid = 1; b4.load_data = prog[i]; b4.load_last = 0;
      step();
    end
    total++; if (b4.run !== 1'b1 || b4.load_count !== 3'd4) begin bad++; $display("FAIL full_auto got run=%b cnt=%0d exp 1/4", b4.run, b4.load_count); end
    b4.load_data = 32'h5555_5555;
    total++; if (b4.load_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", b4.load_ready); end
    step();
    b4.load_valid = 0;
    total++; if (b4.load_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", b4.load_count); end
    b4.req_valid = 1; b4.req_addr = 32'h0;
    step();
    total++; if (b4.rsp_data !== 32'h20080005 || b4.rsp_err !== 1'b0) begin bad++; $display("FAIL full_no_write got d=%h e=%b exp 20080005/0", b4.rsp_data, b4.rsp_err); end
    b4.req_addr = 32'hC;
    step();
    total++; if (b4.rsp_data !== 32'hAC0A0000) begin bad++; $display("FAIL full_last_word got=%h exp=AC0A0000", b4.rsp_data); end
    b4.req_addr = 32'h10;
    step();
    b4.req_valid = 0;
    total++; if (b4.rsp_err !== 1'b1 || b4.rsp_data !== 32'h0) begin bad++; $display("FAIL full_range got e=%b d=%h exp 1/0", b4.rsp_err, b4.rsp_data); end
  endtask
  task automatic test_reset_mid_run();
    b.rsp_ready = 0; b.req_valid = 1; b.req_addr = 32'h4;
    step();
    b.req_valid = 0;
    total++; if (b.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", b.rsp_valid); end
    #2 reset = 1;
    #1;
    total++; if (b.rsp_valid !== 1'b0 || b.run !== 1'b0 || b.load_ready !== 1'b1 || b.load_count !== 11'd0) begin bad++; $display("FAIL mid_async got v=%b run=%b lr=%b cnt=%0d exp 0/0/1/0", b.rsp_valid, b.run, b.load_ready, b.load_count); end
    #1 reset = 0;
    b.rsp_ready = 1;
    step();
    total++; if (b.rsp_valid !== 1'b0 || b.run !== 1'b0) begin bad++; $display("FAIL mid_dropped got v=%b run=%b exp 0/0", b.rsp_valid, b.run); end
    b.load_valid = 1; b.load_data = 32'hDEAD_BEEF; b.load_last = 1;
    step();
    b.load_valid = 0; b.load_last = 0;
    total++; if (b.run !== 1'b1 || b.load_count !== 11'd1) begin bad++; $display("FAIL reload got run=%b cnt=%0d exp 1/1", b.run, b.load_count); end
    b.req_valid = 1; b.req_addr = 32'h0;
    step();
    b.req_valid = 0;
    total++; if (b.rsp_valid !== 1'b1 || b.rsp_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reload_fetch got v=%b d=%h exp 1/DEADBEEF", b.rsp_valid, b.rsp_data); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_full_depth();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
